psum_drain: RTL and testbench

PSUM_DRAIN -- requirements
Module: psum_drain

---
 rtl/psum_drain.sv | 185 ++++++++++++++++++
 tb/tb_psum_drain.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_drain.sv
// -----------------------------------------------------------------------------
// psum_drain
//
// Drains signed partial sums from an upstream synchronous FIFO. Each output
// is the sum of ACC_LEN consecutive words. The sum then gets a bias added,
// an arithmetic right shift by SHIFT, an optional ReLU and 16-bit
// saturation. The result is held on a valid/ready output until it is
// accepted.
//
// Parameters
//   DATA_W   width of a signed FIFO word
//   ACC_LEN  words summed per result (1..128)
//   ACC_W    accumulator width (>= DATA_W+7, so the sum cannot wrap)
//   SHIFT    arithmetic right shift applied before ReLU/saturation (0..15)
//
// Ports
//   clk         clock, all state on the rising edge
//   rst_n       asynchronous active-low reset
//   fifo_empty  upstream FIFO empty flag
//   fifo_rd_en  pop request to the FIFO (combinational)
//   fifo_data   FIFO read data, valid the cycle after a pop
//   bias        signed bias, sampled in FIN
//   relu_en     clamp negative results to zero, sampled in FIN
//   out_data    registered signed 16-bit result
//   out_valid   result valid, held until out_ready
//   out_ready   downstream accept
//   out_sat     result was saturated (qualified by out_valid)
// -----------------------------------------------------------------------------
module psum_drain #(
   parameter int DATA_W  = 25,
   parameter int ACC_LEN = 3,
   parameter int ACC_W   = 32,
   parameter int SHIFT   = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     fifo_empty,
   output logic                     fifo_rd_en,
   input  logic signed [DATA_W-1:0] fifo_data,
   input  logic signed [15:0]       bias,
   input  logic                     relu_en,
   output logic signed [15:0]       out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     out_sat
);

   // Counters must be able to hold ACC_LEN itself.
   localparam int CNT_W = $clog2(ACC_LEN + 1);
   // One spare bit so that adding the bias can never wrap.
   localparam int RES_W = ACC_W + 1;

   localparam logic [CNT_W-1:0]        LEN_C  = CNT_W'(ACC_LEN);
   localparam logic [CNT_W-1:0]        LAST_C = CNT_W'(ACC_LEN - 1);
   localparam logic signed [RES_W-1:0] MAX_C  = RES_W'(32767);
   localparam logic signed [RES_W-1:0] MIN_C  = RES_W'(-32768);

   typedef enum logic [1:0] {
      ST_ACC = 2'd0,
      ST_FIN = 2'd1,
      ST_OUT = 2'd2
   } state_e;

   state_e                    state_q, state_d;
   logic signed [ACC_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]          iss_cnt_q, iss_cnt_d;
   logic [CNT_W-1:0]          rcv_cnt_q, rcv_cnt_d;
   logic                      rd_vld_q;
   logic signed [15:0]        out_data_q, out_data_d;
   logic                      out_valid_q, out_valid_d;
   logic                      out_sat_q, out_sat_d;

   logic                      rd_en;
   logic signed [RES_W-1:0]   fin_v;
   logic [16:0]               sat_res;

   // Floor shift (arithmetic), then optional ReLU on the shifted value.
   function automatic logic signed [RES_W-1:0] shift_relu(
      input logic signed [RES_W-1:0] v,
      input logic                    relu
   );
      logic signed [RES_W-1:0] s;
      s = v >>> SHIFT;
      if (relu && (s < 0)) begin
         s = '0;
      end
      return s;
   endfunction

   // Returns {saturated, value} clamped into the signed 16-bit range.
   function automatic logic [16:0] sat16(input logic signed [RES_W-1:0] v);
      logic [16:0] r;
      if (v > MAX_C) begin
         r = {1'b1, 16'h7FFF};
      end else if (v < MIN_C) begin
         r = {1'b1, 16'h8000};
      end else begin
         r = {1'b0, v[15:0]};
      end
      return r;
   endfunction

   // Pop gating. rst_n is included so that no pop is issued while reset is
   // asserted, even though the reset state would otherwise allow one.
   assign rd_en = rst_n && (state_q == ST_ACC) && !fifo_empty &&
                  (iss_cnt_q < LEN_C);
   assign fifo_rd_en = rd_en;

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      iss_cnt_d   = iss_cnt_q;
      rcv_cnt_d   = rcv_cnt_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_sat_d   = out_sat_q;
      fin_v       = '0;
      sat_res     = '0;

      if (rd_en) begin
         iss_cnt_d = iss_cnt_q + CNT_W'(1);
      end

      case (state_q)
         ST_ACC: begin
            // rd_vld_q marks the cycle in which the word popped one cycle
            // earlier is present on fifo_data.
            if (rd_vld_q) begin
               acc_d     = acc_q + ACC_W'(fifo_data);
               rcv_cnt_d = rcv_cnt_q + CNT_W'(1);
               if (rcv_cnt_q == LAST_C) begin
                  state_d = ST_FIN;
               end
            end
         end
         ST_FIN: begin
            fin_v       = shift_relu(RES_W'(acc_q) + RES_W'(bias), relu_en);
            sat_res     = sat16(fin_v);
            out_data_d  = sat_res[15:0];
            out_sat_d   = sat_res[16];
            out_valid_d = 1'b1;
            state_d     = ST_OUT;
         end
         ST_OUT: begin
            if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
               acc_d       = '0;
               iss_cnt_d   = '0;
               rcv_cnt_d   = '0;
               state_d     = ST_ACC;
            end
         end
         default: begin
            state_d = ST_ACC;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_ACC;
         acc_q       <= '0;
         iss_cnt_q   <= '0;
         rcv_cnt_q   <= '0;
         rd_vld_q    <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_sat_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         iss_cnt_q   <= iss_cnt_d;
         rcv_cnt_q   <= rcv_cnt_d;
         rd_vld_q    <= rd_en;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_sat_q   <= out_sat_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_psum_drain.sv
// -----------------------------------------------------------------------------
// tb_psum_drain
//
// Two instances of psum_drain: u_dut0 with SHIFT=0 and u_dut4 with SHIFT=4.
// Each instance is fed by a small FIFO model. Expected results are queued
// when a group is pushed. A monitor per instance pops the expected result
// and compares it on every output handshake. The monitor for u_dut0 also
// checks that the output holds stable while it is stalled.
// -----------------------------------------------------------------------------
module tb_psum_drain;

   typedef struct packed {
      logic [15:0] d;
      logic        s;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;

   // Instance 0 (SHIFT = 0)
   logic               empty0, rd_en0, relu0, ready0, valid0, sat0, stall0;
   logic signed [24:0] fdata0;
   logic signed [15:0] bias0;
   logic [15:0]        out_data0;
   logic signed [24:0] mem0 [0:63];
   int                 push0 = 0;
   int                 pop0 = 0;
   exp_t               exp0[$];
   exp_t               e0;

   // Instance 1 (SHIFT = 4)
   logic               empty1, rd_en1, relu1, ready1, valid1, sat1, stall1;
   logic signed [24:0] fdata1;
   logic signed [15:0] bias1;
   logic [15:0]        out_data1;
   logic signed [24:0] mem1 [0:63];
   int                 push1 = 0;
   int                 pop1 = 0;
   exp_t               exp1[$];
   exp_t               e1;

   int checks = 0;
   int errors = 0;
   int viol   = 0;

   logic [15:0] hd0;
   logic        hs0;
   bit          held0 = 1'b0;

   always #10 clk = ~clk;

   assign empty0 = stall0 || (push0 == pop0);
   assign empty1 = stall1 || (push1 == pop1);

   psum_drain #(.DATA_W(25), .ACC_LEN(3), .ACC_W(32), .SHIFT(0)) u_dut0 (
      .clk        (clk),
      .rst_n      (rst_n),
      .fifo_empty (empty0),
      .fifo_rd_en (rd_en0),
      .fifo_data  (fdata0),
      .bias       (bias0),
      .relu_en    (relu0),
      .out_data   (out_data0),
      .out_valid  (valid0),
      .out_ready  (ready0),
      .out_sat    (sat0)
   );

   psum_drain #(.DATA_W(25), .ACC_LEN(3), .ACC_W(32), .SHIFT(4)) u_dut4 (
      .clk        (clk),
      .rst_n      (rst_n),
      .fifo_empty (empty1),
      .fifo_rd_en (rd_en1),
      .fifo_data  (fdata1),
      .bias       (bias1),
      .relu_en    (relu1),
      .out_data   (out_data1),
      .out_valid  (valid1),
      .out_ready  (ready1),
      .out_sat    (sat1)
   );

   task automatic check(input string nm, input longint got, input longint want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s got %0d want %0d", nm, got, want);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #2;
   endtask

   task automatic push_w0(input int v);
      if (push0 < 64) mem0[push0] = 25'(v);
      push0++;
   endtask

   task automatic push_w1(input int v);
      if (push1 < 64) mem1[push1] = 25'(v);
      push1++;
   endtask

   task automatic wait_done0(input int budget);
      int n = 0;
      while ((exp0.size() != 0 || valid0) && n < budget) begin
         step();
         n++;
      end
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL timeout0 got %0d cycles want < %0d", n, budget);
      end
   endtask

   task automatic wait_done1(input int budget);
      int n = 0;
      while ((exp1.size() != 0 || valid1) && n < budget) begin
         step();
         n++;
      end
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL timeout1 got %0d cycles want < %0d", n, budget);
      end
   endtask

   // FIFO models: a pop in cycle n makes the word visible in cycle n+1.
   always @(posedge clk) begin
      if (rd_en0) begin
         #1;
         if (pop0 < 64) fdata0 = mem0[pop0];
         pop0 = pop0 + 1;
      end
   end

   always @(posedge clk) begin
      if (rd_en1) begin
         #1;
         if (pop1 < 64) fdata1 = mem1[pop1];
         pop1 = pop1 + 1;
      end
   end

   // Pop requests must never be issued while the FIFO is empty.
   always begin
      @(negedge clk);
      #5;
      if ((rd_en0 && empty0) || (rd_en1 && empty1)) viol++;
   end

   // Monitor for instance 0.
   always begin
      @(negedge clk);
      #5;
      if (rst_n && valid0) begin
         check("rd_en_in_out0", rd_en0, 0);
         if (held0) begin
            check("hold_data0", out_data0, hd0);
            check("hold_sat0", sat0, hs0);
         end
         if (ready0) begin
            if (exp0.size() == 0) begin
               check("unexpected_out0", 1, 0);
            end else begin
               e0 = exp0.pop_front();
               check("out_data0", out_data0, e0.d);
               check("out_sat0", sat0, e0.s);
            end
            held0 = 1'b0;
         end else begin
            held0 = 1'b1;
            hd0   = out_data0;
            hs0   = sat0;
         end
      end else begin
         held0 = 1'b0;
      end
   end

   // Monitor for instance 1.
   always begin
      @(negedge clk);
      #5;
      if (rst_n && valid1 && ready1) begin
         if (exp1.size() == 0) begin
            check("unexpected_out1", 1, 0);
         end else begin
            e1 = exp1.pop_front();
            check("out_data1", out_data1, e1.d);
            check("out_sat1", sat1, e1.s);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int first, last, cnt, vidx, n;
      rst_n  = 1'b0;
      stall0 = 1'b0; stall1 = 1'b0;
      ready0 = 1'b1; ready1 = 1'b1;
      bias0  = '0;   bias1  = '0;
      relu0  = 1'b0; relu1  = 1'b0;
      fdata0 = '0;   fdata1 = '0;

      // Reset with data available: no pop, outputs cleared.
      push_w0(1); push_w0(2); push_w0(10);
      step(); step();
      check("rst_rd_en", rd_en0, 0);
      check("rst_out_data", out_data0, 0);
      check("rst_out_valid", valid0, 0);
      check("rst_out_sat", sat0, 0);

      // Basic group 1+2+10 = 13, three back-to-back pops.
      exp0.push_back('{d: 16'd13, s: 1'b0});
      rst_n = 1'b1;
      #1;
      check("rel_rd_en", rd_en0, 1);
      first = -1; last = -1; cnt = 0; vidx = -1; n = 0;
      while (vidx < 0 && n < 20) begin
         if (rd_en0) begin
            cnt++;
            if (first < 0) first = n;
            last = n;
         end
         if (valid0) vidx = n;
         if (vidx < 0) begin
            step();
            n++;
         end
      end
      check("basic_pops", cnt, 3);
      check("basic_consec", last - first, 2);
      check("basic_latency", vidx - last, 3);
      wait_done0(20);

      // Sign and ReLU: -5-6+4+2 = -5.
      bias0 = 16'sd2;
      exp0.push_back('{d: 16'hFFFB, s: 1'b0});
      push_w0(-5); push_w0(-6); push_w0(4);
      wait_done0(20);
      relu0 = 1'b1;
      exp0.push_back('{d: 16'h0000, s: 1'b0});
      push_w0(-5); push_w0(-6); push_w0(4);
      wait_done0(20);
      relu0 = 1'b0;
      bias0 = '0;

      // Saturation at both rails.
      exp0.push_back('{d: 16'h7FFF, s: 1'b1});
      push_w0(16777215); push_w0(16777215); push_w0(16777215);
      wait_done0(20);
      exp0.push_back('{d: 16'h8000, s: 1'b1});
      push_w0(-16777216); push_w0(-16777216); push_w0(-16777216);
      wait_done0(20);

      // Input stalls and output back-pressure: 100-30+7 = 77.
      ready0 = 1'b0;
      exp0.push_back('{d: 16'd77, s: 1'b0});
      push_w0(100); push_w0(-30); push_w0(7);
      for (int i = 0; i < 8; i++) begin
         step();
         stall0 = (i % 2 == 1);
      end
      step();
      stall0 = 1'b0;
      n = 0;
      while (!valid0 && n < 40) begin
         step();
         n++;
      end
      check("stall_valid_seen", (n < 40) ? 1 : 0, 1);
      for (int k = 0; k < 4; k++) begin
         step();
         check("stall_rd_en", rd_en0, 0);
         check("stall_valid", valid0, 1);
      end
      exp0.push_back('{d: 16'd15, s: 1'b0});
      push_w0(4); push_w0(5); push_w0(6);
      ready0 = 1'b1;
      step();
      check("next_grp_rd_en", rd_en0, 1);
      check("next_grp_valid", valid0, 0);
      wait_done0(20);

      // Reset after two of three words: partial sum discarded.
      push_w0(50); push_w0(60);
      for (int k = 0; k < 6; k++) step();
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", valid0, 0);
      check("mid_rst_data", out_data0, 0);
      check("mid_rst_sat", sat0, 0);
      push_w0(7); push_w0(8); push_w0(9);
      step();
      check("mid_rst_rd_en", rd_en0, 0);
      exp0.push_back('{d: 16'd24, s: 1'b0});
      rst_n = 1'b1;
      wait_done0(20);

      // SHIFT=4 instance: 0x100 -> 0x10, -1 -> -1, -17 -> -2 (floor).
      exp1.push_back('{d: 16'h0010, s: 1'b0});
      push_w1(128); push_w1(128); push_w1(0);
      exp1.push_back('{d: 16'hFFFF, s: 1'b0});
      push_w1(-1); push_w1(0); push_w1(0);
      exp1.push_back('{d: 16'hFFFE, s: 1'b0});
      push_w1(-20); push_w1(3); push_w1(0);
      wait_done1(40);

      step();
      check("pops0", pop0, push0);
      check("pops1", pop1, push1);
      check("empty_viol", viol, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
